// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the single-clock FIFO.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sync_fifo_pkg;

    // Default word width and entry count. The depth default must stay a power of two.
    localparam int unsigned SYNC_FIFO_DEF_WIDTH = 16;
    localparam int unsigned SYNC_FIFO_DEF_DEPTH = 8;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// Dual-port register array with one write port and one registered read port.
// Latency: rdata_o updates on the edge that samples re_i (1 cycle).
// Backpressure: none; the caller qualifies we_i/re_i with the full/empty state.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned Width = SYNC_FIFO_DEF_WIDTH,
    parameter int unsigned Depth = SYNC_FIFO_DEF_DEPTH,
    parameter int unsigned AW    = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    // Storage is not reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register holds its value unless a read is accepted; clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : sync_fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock FIFO of Depth words, Width bits each, with full/empty flags.
// Latency: read data appears on d_out the cycle after the read is accepted; no write-to-read bypass.
// Backpressure: writes while full and reads while empty are silently dropped.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned Width = SYNC_FIFO_DEF_WIDTH,
    parameter int unsigned Depth = SYNC_FIFO_DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_en,
    input  logic             read_en,
    input  logic [Width-1:0] d_in,
    output logic [Width-1:0] d_out,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(Depth);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        wr_acc;
    logic        rd_acc;

    // Flags come straight from the registered pointers, so they lag the causing edge by one cycle.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    end

    // Acceptance uses the pre-edge flags: a read does not free space for a same-cycle write.
    always_comb begin
        wr_acc   = write_en && !full;
        rd_acc   = read_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Pointer registers; reset wins over any concurrent request.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    sync_fifo_mem #(
        .Width (Width),
        .Depth (Depth),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_acc && !rst),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (d_in),
        .re_i    (rd_acc && !rst),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (d_out)
    );

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (Width=16, Depth=8).
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: overflow and underflow attempts are exercised directly.
module tb_sync_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_en;
    logic        read_en;
    logic [15:0] d_in;
    logic [15:0] d_out;
    logic        full;
    logic        empty;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo #(
        .Width (16),
        .Depth (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .write_en (write_en),
        .read_en  (read_en),
        .d_in     (d_in),
        .d_out    (d_out),
        .full     (full),
        .empty    (empty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic we, input logic re, input logic [15:0] d);
        rst      = r;
        write_en = we;
        read_en  = re;
        d_in     = d;
    endtask

    initial begin
        logic [15:0] last_wr;

        // Reset with write_en held high: write must be overridden.
        drive(1'b1, 1'b1, 1'b0, 16'h0055);
        step();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);
        check("rst_dout",  32'(d_out), 32'h0);
        step();
        check("rst_hold_empty", 32'(empty), 32'd1);

        // Streaming from empty with both enables high.
        drive(1'b0, 1'b1, 1'b1, 16'h00AA);
        step();
        check("stream_e1_empty", 32'(empty), 32'd0);
        check("stream_e1_dout",  32'(d_out), 32'h0);
        step();
        check("stream_e2_dout",  32'(d_out), 32'h00AA);
        last_wr = 16'h00AA;
        for (int i = 0; i < 7; i++) begin
            d_in = (i < 5) ? 16'h00CC : 16'h00AB;
            step();
            check("stream_dout", 32'(d_out), 32'(last_wr));
            check("stream_full", 32'(full),  32'd0);
            check("stream_empty", 32'(empty), 32'd0);
            last_wr = d_in;
        end
        // Drain the one in-flight word.
        drive(1'b0, 1'b0, 1'b1, 16'h0000);
        step();
        check("stream_drain_dout",  32'(d_out), 32'h00AB);
        check("stream_drain_empty", 32'(empty), 32'd1);

        // Fill with 1..8.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'(i));
            step();
            check("fill_full", 32'(full), (i == 8) ? 32'd1 : 32'd0);
        end
        // Overflow attempt.
        drive(1'b0, 1'b1, 1'b0, 16'd9);
        step();
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_dout", 32'(d_out), 32'h00AB);

        // Drain 1..8 in order.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b0, 1'b1, 16'h0);
            step();
            check("drain_dout",  32'(d_out), 32'(i));
            check("drain_empty", 32'(empty), (i == 8) ? 32'd1 : 32'd0);
        end
        // Underflow attempt: d_out holds.
        step();
        check("udf_dout",  32'(d_out), 32'd8);
        check("udf_empty", 32'(empty), 32'd1);

        // Wrap: 5 in, 5 out, 8 in, 8 out.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'(16'h20 + i));
            step();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 16'h0);
            step();
            check("wrap5_dout", 32'(d_out), 32'(16'h20 + i));
        end
        check("wrap5_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'(16'h10 + i));
            step();
            check("wrap8_full",  32'(full),  (i == 7) ? 32'd1 : 32'd0);
            check("wrap8_empty", 32'(empty), 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b1, 16'h0);
            step();
            check("wrap8_dout",  32'(d_out), 32'(16'h10 + i));
            check("wrap8_rfull", 32'(full),  32'd0);
            check("wrap8_remp",  32'(empty), (i == 7) ? 32'd1 : 32'd0);
        end

        // Fill, then simultaneous read+write while full.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'(16'h30 + i));
            step();
        end
        check("sim_pre_full", 32'(full), 32'd1);
        drive(1'b0, 1'b1, 1'b1, 16'h0099);
        step();
        check("sim_dout", 32'(d_out), 32'h0030);
        check("sim_full", 32'(full),  32'd0);
        // Read 4 more, leaving 3 entries; the blocked 0x99 must not appear.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 16'h0);
            step();
            check("sim_rd_dout", 32'(d_out), 32'(16'h30 + i));
        end
        check("sim_rd_empty", 32'(empty), 32'd0);

        // Mid-operation reset with 3 entries held and a read requested.
        drive(1'b1, 1'b0, 1'b1, 16'h0);
        step();
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_full",  32'(full),  32'd0);
        check("mid_rst_dout",  32'(d_out), 32'h0);
        drive(1'b0, 1'b0, 1'b1, 16'h0);
        step();
        check("post_rst_udf_dout", 32'(d_out), 32'h0);
        // Pointers restart cleanly after reset.
        drive(1'b0, 1'b1, 1'b0, 16'h0042);
        step();
        drive(1'b0, 1'b0, 1'b1, 16'h0);
        step();
        check("post_rst_dout",  32'(d_out), 32'h0042);
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sync_fifo

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, first-in-first-out buffer; Depth entries of Width bits each.
- Write and read ports use simple enable handshakes, with full and empty status flags.
- Used as a rate-decoupling buffer between a producer and a consumer in the same clock domain.
- Read data is registered: it appears on d_out the cycle after the read is accepted.

Parameters:
- Width, 16, data word width in bits (≥1).
- Depth, 8, number of storage entries. Must be a power of two, ≥2.
- AW (derived, local), log2(Depth), address width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- write_en  input  1  write request; sampled at the clk rising edge.
- read_en  input  1  read request; sampled at the clk rising edge.
- d_in  input  Width  write data; captured when the write is accepted.
- d_out  output  Width  registered read data.
- full  output  1  high when the FIFO holds Depth entries.
- empty  output  1  high when the FIFO holds 0 entries.

Behaviour:
- One clock, clk. rst is synchronous and active-high. All state updates happen only on the rising edge of clk.
- Reset (rst=1 at an edge):
  - write and read pointers go to 0; occupancy count goes to 0.
  - empty=1, full=0, d_out=0.
  - rst overrides write_en and read_en in the same cycle.
  - Reset mid-operation discards all stored data. Memory contents need not be cleared.
- Pointers are AW+1 bits wide; the extra MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (low AW bits equal) && (MSBs differ).
  - Both flags are combinational from the registered pointers, so they update the cycle after the causing edge.
- Write accepted = write_en && !full.
  - mem[wr_ptr[AW-1:0]] <= d_in; wr_ptr increments modulo 2^(AW+1).
- Read accepted = read_en && !empty.
  - d_out <= mem[rd_ptr[AW-1:0]]; rd_ptr increments.
  - Latency: the data is visible on d_out after the same edge that accepts the read.
- d_out holds its last value when no read is accepted, including during underflow attempts.
- Overflow (write_en while full): write ignored, no state change, no error flag.
- Underflow (read_en while empty): read ignored, no state change.
- Simultaneous write_en and read_en:
  - Empty: only the write is accepted. The read is ignored because empty is evaluated before the edge. Next cycle: 1 entry, empty=0.
  - Full: only the read is accepted. The write is blocked, because full is evaluated before the edge and is not qualified by the concurrent read. Next cycle: Depth-1 entries.
  - Otherwise: both are accepted and occupancy is unchanged.
  - The read never returns the word being written in that same cycle; there is no bypass path.
- Wrap-around: the pointers roll from Depth-1 to 0 in their low bits and toggle the MSB. Ordering is preserved across the wrap.

Decomposition:
- Shared package: no typedefs are required. Width and Depth stay as module parameters; AW is derived locally with $clog2.
- One natural sub-module: sync_fifo_mem, a simple dual-port register array.
  - One write port: we, waddr, wdata.
  - One synchronous read port: re, raddr, registered rdata, reset to 0.
- Pointer and flag logic stays in sync_fifo.

Test Plan:
- Reset: assert rst for one edge → empty=1, full=0, d_out=0. Hold write_en=1 during reset → still empty=1 afterwards.
- Streaming from empty: release rst; hold write_en=1, read_en=1, d_in=0xAA.
  - After edge 1: empty=0; d_out remains 0 (the read was ignored).
  - After edge 2: d_out=0xAA.
  - Change d_in to 0xCC for 5 cycles, then to 0xAB: d_out follows each new value 1 cycle later. Occupancy stays at 1, full never asserts.
- Fill: write 8 words 1..8 with read_en=0 → full=1 after the 8th edge. A 9th write of 9 is ignored.
- Drain: read the 8 words → d_out = 1,2,…,8 in order; empty=1 after the 8th read. Another read leaves d_out=8.
- Wrap: write 5, read 5, write 8 more (values 0x10..0x17), read 8 → correct order, full/empty correct throughout.
- Simultaneous at full, then mid-operation reset: at full, write_en=read_en=1 → one word read, write blocked, full drops. Assert rst with 3 entries held → empty=1, d_out=0 next cycle.
